// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Token-exchange round sequencer: snapshots per-processor start/stop events on go,
// scans sources in order and streams (target, delta) beats over valid/ready.
module tt_um_jleugeri_ttt_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int IDX_W          = $clog2(NUM_PROCESSORS),
  parameter int MAX_FANOUT     = 8,
  parameter int LEN_W          = $clog2(MAX_FANOUT + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go_in,
  input  logic [2*NUM_PROCESSORS-1:0] tstartstop_in,
  input  logic                        cfg_we,
  input  logic [IDX_W-1:0]            cfg_src,
  input  logic [IDX_W-1:0]            cfg_base,
  input  logic [LEN_W-1:0]            cfg_len,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [IDX_W-1:0]            src_idx_out,
  output logic                        tgt_valid,
  input  logic                        tgt_ready,
  output logic [IDX_W-1:0]            tgt_idx,
  output logic [1:0]                  tgt_delta
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DISPATCH, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_SRC = IDX_W'(NUM_PROCESSORS - 1);
  localparam logic [IDX_W:0]   N_EXT    = (IDX_W + 1)'(NUM_PROCESSORS);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FANOUT);

  state_t                        state_q, state_d;
  logic [2*NUM_PROCESSORS-1:0]   evt_q, evt_d;
  logic [IDX_W-1:0]              src_q, src_d;
  logic [LEN_W-1:0]              k_q, k_d;
  logic [IDX_W-1:0]              base_q [NUM_PROCESSORS];
  logic [LEN_W-1:0]              len_q  [NUM_PROCESSORS];

  logic [IDX_W-1:0] cur_base;
  logic [LEN_W-1:0] cur_len;
  logic             ev_start, ev_stop;
  logic [1:0]       delta;
  logic [IDX_W:0]   sum, wrapped;
  logic             cfg_ok;

  assign cur_base = base_q[src_q];
  assign cur_len  = len_q[src_q];
  assign ev_start = evt_q[{src_q, 1'b0}];
  assign ev_stop  = evt_q[{src_q, 1'b1}];

  always_comb begin
    delta = 2'b00;
    unique case ({ev_stop, ev_start})
      2'b01:   delta = 2'b01;
      2'b10:   delta = 2'b11;
      default: delta = 2'b00;
    endcase
  end

  // base < N and k < MAX_FANOUT <= N, so one conditional subtract is a full mod-N reduction.
  assign sum     = (IDX_W + 1)'(cur_base) + (IDX_W + 1)'(k_q);
  assign wrapped = (sum >= N_EXT) ? (sum - N_EXT) : sum;

  assign busy_out    = (state_q != S_IDLE);
  assign done_out    = (state_q == S_DONE);
  assign tgt_valid   = (state_q == S_DISPATCH);
  assign src_idx_out = src_q;
  assign tgt_idx     = tgt_valid ? wrapped[IDX_W-1:0] : '0;
  assign tgt_delta   = tgt_valid ? delta : '0;

  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    src_d   = src_q;
    k_d     = k_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_in) begin
          state_d = S_SCAN;
          evt_d   = tstartstop_in;
          src_d   = '0;
        end
      end
      S_SCAN: begin
        if (delta != 2'b00 && cur_len != '0) begin
          state_d = S_DISPATCH;
          k_d     = '0;
        end else if (src_q == LAST_SRC) begin
          state_d = S_DONE;
        end else begin
          src_d = src_q + 1'b1;
        end
      end
      S_DISPATCH: begin
        if (tgt_ready) begin
          if (k_q == cur_len - LEN_W'(1)) begin
            if (src_q == LAST_SRC) begin
              state_d = S_DONE;
            end else begin
              state_d = S_SCAN;
              src_d   = src_q + 1'b1;
            end
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      evt_q   <= '0;
      src_q   <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      src_q   <= src_d;
      k_q     <= k_d;
    end
  end

  // Writes only land in IDLE, so the table is frozen for the whole round.
  assign cfg_ok = (state_q == S_IDLE) && cfg_we &&
                  (cfg_src <= LAST_SRC) && (cfg_base <= LAST_SRC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_PROCESSORS; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else if (cfg_ok) begin
      base_q[cfg_src] <= cfg_base;
      len_q[cfg_src]  <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_scheduler.sv
// Scoreboard bench for the token-exchange scheduler: directed rounds push expected
// beats/done cycles; a negedge monitor pops and compares them.
module tb_tt_um_jleugeri_ttt_scheduler;

  localparam int N = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        go_in;
  logic [19:0] tss;
  logic        cfg_we;
  logic [3:0]  cfg_src, cfg_base, cfg_len;
  logic        busy_out, done_out, tgt_valid, tgt_ready;
  logic [3:0]  src_idx_out, tgt_idx;
  logic [1:0]  tgt_delta;

  tt_um_jleugeri_ttt_scheduler #(.NUM_PROCESSORS(N), .MAX_FANOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .go_in(go_in), .tstartstop_in(tss),
    .cfg_we(cfg_we), .cfg_src(cfg_src), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .busy_out(busy_out), .done_out(done_out), .src_idx_out(src_idx_out),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_idx(tgt_idx), .tgt_delta(tgt_delta)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int delta; int src; int cyc;} beat_t;
  beat_t exp_q[$];
  int    done_q[$];
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares every accepted beat and every done pulse against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tgt_valid && tgt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(tgt_idx), -1);
        end else begin
          beat_t b;
          int    d;
          b = exp_q.pop_front();
          d = int'($signed(tgt_delta));
          check("beat_idx", int'(tgt_idx), b.idx);
          check("beat_delta", d, b.delta);
          check("beat_src", int'(src_idx_out), b.src);
          check("beat_cycle", cyc, b.cyc);
        end
      end
      if (done_out) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("beats_left_at_done", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input int idx, input int delta, input int src, input int c);
    beat_t b;
    b.idx = idx; b.delta = delta; b.src = src; b.cyc = c;
    exp_q.push_back(b);
  endtask

  task automatic cfg(input int src, input int base, input int len);
    next();
    cfg_we = 1'b1; cfg_src = 4'(src); cfg_base = 4'(base); cfg_len = 4'(len);
    next();
    cfg_we = 1'b0;
  endtask

  // Drives go in the current cycle g; the caller releases go one cycle later.
  task automatic start_round(input logic [19:0] ev, input int done_off, output int g);
    next();
    tss = ev; go_in = 1'b1; g = cyc;
    if (done_off >= 0) done_q.push_back(g + done_off);
  endtask

  task automatic end_go(input logic [19:0] ev);
    next();
    go_in = 1'b0; tss = ~ev;
  endtask

  task automatic wait_round();
    for (int i = 0; i < 300; i++) begin
      if (done_q.size() == 0 && exp_q.size() == 0) return;
      next();
    end
    check("round_timeout", 1, 0);
    done_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int g;
    rst_n = 1'b0; go_in = 1'b0; tss = '0; cfg_we = 1'b0;
    cfg_src = '0; cfg_base = '0; cfg_len = '0; tgt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_out), 0);
    check("rst_done", int'(done_out), 0);
    check("rst_valid", int'(tgt_valid), 0);
    check("rst_src", int'(src_idx_out), 0);
    check("rst_idx", int'(tgt_idx), 0);
    check("rst_delta", int'(tgt_delta), 0);
    rst_n = 1'b1;

    // 1: no events, done at g+11, busy over g+1..g+11
    start_round(20'h00000, 11, g);
    @(negedge clk);
    check("t1_busy_c0", int'(busy_out), 0);
    for (int i = 1; i <= 12; i++) begin
      next();
      if (i == 1) begin go_in = 1'b0; tss = '1; end
      @(negedge clk);
      check($sformatf("t1_busy_c%0d", i), int'(busy_out), (i <= 11) ? 1 : 0);
    end
    wait_round();

    // 2: src3 start, table[3]={5,2}, back-to-back beats
    cfg(3, 5, 2);
    start_round(20'h00040, 13, g);
    push_beat(5, 1, 3, g + 5);
    push_beat(6, 1, 3, g + 6);
    end_go(20'h00040);
    wait_round();

    // 3: src9 stop, table[9]={8,4}, wrap-around
    cfg(9, 8, 4);
    start_round(20'h80000, 15, g);
    push_beat(8, -1, 9, g + 11);
    push_beat(9, -1, 9, g + 12);
    push_beat(0, -1, 9, g + 13);
    push_beat(1, -1, 9, g + 14);
    end_go(20'h80000);
    wait_round();

    // 4: src2 start+stop skipped; table[4]={0,1} written in the go cycle
    cfg(2, 7, 3);
    start_round(20'h00130, 12, g);
    cfg_we = 1'b1; cfg_src = 4'd4; cfg_base = 4'd0; cfg_len = 4'd1;
    push_beat(0, 1, 4, g + 6);
    end_go(20'h00130);
    cfg_we = 1'b0;
    wait_round();

    // clamp: table[7]={2,15} -> 8 targets 2..9
    cfg(7, 2, 15);
    start_round(20'h04000, 19, g);
    for (int k = 0; k < 8; k++) push_beat(2 + k, 1, 7, g + 9 + k);
    end_go(20'h04000);
    wait_round();

    // 5: backpressure, ignored go and cfg_we mid-round
    cfg(0, 3, 2);
    tgt_ready = 1'b0;
    start_round(20'h00001, 16, g);
    push_beat(3, 1, 0, g + 5);
    push_beat(4, 1, 0, g + 6);
    end_go(20'h00001);
    for (int i = 2; i <= 4; i++) begin
      next();
      go_in = (i == 2); cfg_we = (i == 2);
      cfg_src = 4'd0; cfg_base = 4'd9; cfg_len = 4'd1;
      @(negedge clk);
      check($sformatf("t5_hold_valid_c%0d", i), int'(tgt_valid), 1);
      check($sformatf("t5_hold_idx_c%0d", i), int'(tgt_idx), 3);
      check($sformatf("t5_hold_delta_c%0d", i), int'($signed(tgt_delta)), 1);
    end
    next();
    tgt_ready = 1'b1;
    wait_round();

    // 6: reset in DISPATCH aborts the round and clears the table
    cfg(1, 2, 3);
    tgt_ready = 1'b0;
    start_round(20'h00004, -1, g);
    end_go(20'h00004);
    next();
    next();
    @(negedge clk);
    check("t6_pre_valid", int'(tgt_valid), 1);
    check("t6_pre_idx", int'(tgt_idx), 2);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy_out), 0);
    check("t6_rst_valid", int'(tgt_valid), 0);
    check("t6_rst_idx", int'(tgt_idx), 0);
    check("t6_rst_delta", int'(tgt_delta), 0);
    check("t6_rst_src", int'(src_idx_out), 0);
    check("t6_rst_done", int'(done_out), 0);
    next();
    next();
    rst_n = 1'b1;
    tgt_ready = 1'b1;
    start_round(20'h55555, 11, g);
    end_go(20'h55555);
    wait_round();
    check("final_beats_left", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
